instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV32I OP / OP-IMM instruction encoder and instruction-memory loader; the inverse of the core's instruction decoder.
- Accepts decoded fields (internal alu_op code, register indices, imm12, is_from_rf) over a valid/ready stream.
- Emits 32-bit instruction words as sequential writes into instruction memory, starting at a programmable base address.
- Used by the test/boot path to build programs in hardware. Each program load is one run: start, then len words, then done.

Parameters:
- ADDR_W, 8, width of imem word address; address arithmetic wraps modulo 2^ADDR_W.
- LEN_W, 8, width of program length and error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a run when the FSM is IDLE or DONE
- base_addr  in  ADDR_W  first imem word address; sampled on start
- len  in  LEN_W  number of instructions in the run; sampled on start
- in_valid  in  1  encode request valid
- in_ready  out  1  encoder accepts the request this cycle
- in_alu_op  in  5  1 ADD, 2 XOR, 3 OR, 4 AND, 5 SUB, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, A SLT
- in_is_from_rf  in  1  1 = register-register (OP), 0 = immediate (OP-IMM)
- in_rd, in_rs1, in_rs2  in  5 each  register indices; rs2 ignored when is_from_rf=0
- in_imm12  in  12  immediate; ignored when is_from_rf=1
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  FSM in RUN
- done  out  1  one-cycle pulse at end of run
- err_cnt  out  LEN_W  illegal requests seen in the current run; saturates at all-ones

Behaviour:
- Reset values (async, rst_n low): FSM IDLE; in_ready, imem_we, done, busy = 0; imem_addr, imem_wdata, err_cnt, internal address and remaining count = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE --start--> RUN. On that edge: latch base_addr and len, clear err_cnt.
- If the latched len = 0, go from RUN to DONE on the next cycle, pulse done, perform no writes.
- RUN: in_ready = 1. A beat transfers when in_valid && in_ready.
- RUN --last beat accepted (remaining count 1->0)--> DONE. done pulses in the cycle after the last beat, coincident with the last imem_we.
- DONE behaves as IDLE but records completion. start is ignored while in RUN.
- Latency: a beat accepted at edge N drives imem_we=1, imem_addr and imem_wdata (all registered) during cycle N+1.
- imem_we is 0 in every cycle with no accepted beat. No backpressure from imem.
- Address post-increments per accepted beat and wraps from 2^ADDR_W-1 to 0.
- Encoding, is_from_rf=1:
  - opcode 0110011; {funct7, rs2, rs1, funct3, rd, opcode}.
  - funct7 = 0100000 for SUB and SRA, else 0.
- Encoding, is_from_rf=0:
  - opcode 0010011; {imm12, rs1, funct3, rd, opcode}.
  - For SLLI/SRLI/SRAI, bits [31:25] are forced to funct7 and [24:20] = imm12[4:0].
- funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- Illegal requests:
  - alu_op = 0 or > 0xA.
  - SUB with is_from_rf=0.
  - Immediate shift with imm12[11:5] != 0.
- An illegal request is still accepted and still consumes an address and a count. It writes the NOP 0x00000013 and increments err_cnt (saturating).
- Reset mid-run aborts immediately: no done pulse, all outputs return to reset values.

Decomposition:
- Shared package holds:
  - alu_op code constants, shared with the decoder.
  - OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011.
  - funct3/funct7 constants and NOP_WORD = 32'h00000013.
- One combinational sub-module, instr_pack: maps fields to {word, illegal}.
- The top level holds the FSM, counters and output registers.

Test Plan:
- start base=0x10, len=1; ADDI rd=1, rs1=0, imm=5 -> next cycle imem_we=1, addr=0x10, wdata=0x00500093, done=1.
- len=2; ADD x3,x1,x2, then SUB x3,x1,x2, back-to-back -> wdata 0x002081B3 @0x00 and 0x402081B3 @0x01, done with the second write.
- SRAI rd=5, rs1=6, imm=3 -> 0x40335293. SRLI with imm12=0x023 -> NOP 0x00000013, err_cnt=1.
- base=0xFF, len=2, ADDI beats with in_valid gaps -> writes at 0xFF then 0x00, imem_we low in gap cycles.
- len=0 -> done one cycle after start, no imem_we. start during RUN -> ignored, addresses unaffected.
- rst_n low during RUN after 1 of 3 beats -> outputs reset at once, no done, next start begins a fresh run.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I OP/OP-IMM encoding constants and request bundle types.
// Imported by instr_pack and instr_encoder; alu_op codes match the decoder.
package instr_encoder_pkg;

  localparam logic [4:0] ALU_ADD  = 5'h1;
  localparam logic [4:0] ALU_XOR  = 5'h2;
  localparam logic [4:0] ALU_OR   = 5'h3;
  localparam logic [4:0] ALU_AND  = 5'h4;
  localparam logic [4:0] ALU_SUB  = 5'h5;
  localparam logic [4:0] ALU_SLTU = 5'h6;
  localparam logic [4:0] ALU_SLL  = 5'h7;
  localparam logic [4:0] ALU_SRL  = 5'h8;
  localparam logic [4:0] ALU_SRA  = 5'h9;
  localparam logic [4:0] ALU_SLT  = 5'hA;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic        is_from_rf;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm12;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_rsp_t;

  function automatic logic is_shift(
    input logic [4:0] op
  );
    return (op == ALU_SLL) ||
           (op == ALU_SRL) ||
           (op == ALU_SRA);
  endfunction

  function automatic logic uses_alt(
    input logic [4:0] op
  );
    return (op == ALU_SUB) ||
           (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded request -> {instruction word, illegal}.
// Ports: req (decoded fields), rsp (word, NOP when illegal, plus flag).
module instr_pack
  import instr_encoder_pkg::*;
(
  input  enc_req_t req,
  output enc_rsp_t rsp
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       known;
  logic       shift;
  logic       bad_imm;
  logic       bad_sub;

  always_comb begin
    f3    = F3_ADD_SUB;
    known = 1'b1;
    unique case (1'b1)
      (req.alu_op == ALU_ADD),
      (req.alu_op == ALU_SUB):  f3 = F3_ADD_SUB;
      (req.alu_op == ALU_SLL):  f3 = F3_SLL;
      (req.alu_op == ALU_SLT):  f3 = F3_SLT;
      (req.alu_op == ALU_SLTU): f3 = F3_SLTU;
      (req.alu_op == ALU_XOR):  f3 = F3_XOR;
      (req.alu_op == ALU_SRL),
      (req.alu_op == ALU_SRA):  f3 = F3_SRL_SRA;
      (req.alu_op == ALU_OR):   f3 = F3_OR;
      (req.alu_op == ALU_AND):  f3 = F3_AND;
      default:                  known = 1'b0;
    endcase
  end

  assign f7    = uses_alt(req.alu_op) ? F7_ALT : F7_BASE;
  assign shift = is_shift(req.alu_op);

  // There is no SUBI; immediate shifts only encode a 5-bit shamt.
  assign bad_sub = (req.alu_op == ALU_SUB) && !req.is_from_rf;
  assign bad_imm = shift && !req.is_from_rf &&
                   (req.imm12[11:5] != 7'd0);

  always_comb begin
    rsp.illegal = !known || bad_sub || bad_imm;
    rsp.word    = NOP_WORD;
    if (rsp.illegal) begin
      rsp.word = NOP_WORD;
    end else if (req.is_from_rf) begin
      rsp.word = {f7, req.rs2, req.rs1,
                  f3, req.rd, OPC_OP};
    end else if (shift) begin
      rsp.word = {f7, req.imm12[4:0], req.rs1,
                  f3, req.rd, OPC_OPIMM};
    end else begin
      rsp.word = {req.imm12, req.rs1,
                  f3, req.rd, OPC_OPIMM};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming OP/OP-IMM encoder that writes a program into imem per run.
// Ports: start/base_addr/len run control, in_* request stream, imem_* writes, busy/done/err_cnt status.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_alu_op,
  input  logic              in_is_from_rf,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm12,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_cnt
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem;
  logic              accept;
  logic              last;
  enc_req_t          req;
  enc_rsp_t          rsp;

  assign req = '{
    alu_op:     in_alu_op,
    is_from_rf: in_is_from_rf,
    rd:         in_rd,
    rs1:        in_rs1,
    rs2:        in_rs2,
    imm12:      in_imm12
  };

  instr_pack u_pack (
    .req (req),
    .rsp (rsp)
  );

  assign busy = (state == ST_RUN);
  // A zero-length run sits in RUN for one cycle without accepting.
  assign in_ready = busy && (rem != '0);
  assign accept   = in_valid && in_ready;
  assign last     = (rem == '0) ||
                    (accept && rem == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      rem        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      imem_we <= accept;
      done    <= 1'b0;
      if (accept) begin
        imem_addr  <= addr_q;
        imem_wdata <= rsp.word;
        addr_q     <= addr_q + ADDR_W'(1);
        rem        <= rem - LEN_W'(1);
        if (rsp.illegal && (err_cnt != '1))
          err_cnt <= err_cnt + LEN_W'(1);
      end
      unique case (1'b1)
        (state == ST_RUN): begin
          if (last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        (state == ST_IDLE),
        (state == ST_DONE): begin
          if (start) begin
            state   <= ST_RUN;
            addr_q  <= base_addr;
            rem     <= len;
            err_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random runs.
// A behavioural model predicts every output; a negedge process compares.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_alu_op = '0;
  logic        in_is_from_rf = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [11:0] in_imm12 = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;

  instr_encoder #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .len           (len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_is_from_rf (in_is_from_rf),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm12      (in_imm12),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  bit          e_run = 0;
  int          e_rem = 0;
  int          e_ptr = 0;
  int          e_err = 0;
  bit          e_we = 0;
  bit          e_done = 0;
  logic [7:0]  e_addr = '0;
  logic [31:0] e_wd = '0;

  function automatic logic [32:0] ref_enc(
    input int op, input bit rf, input int rd,
    input int rs1, input int rs2, input int imm
  );
    int     f3tab[11];
    bit     ill;
    bit     sh;
    longint f7;
    longint w;
    f3tab = '{0, 0, 4, 6, 7, 0, 3, 1, 5, 5, 2};
    sh  = (op >= 7) && (op <= 9);
    ill = (op < 1) || (op > 10) || (op == 5 && !rf) ||
          (!rf && sh && (imm / 32) != 0);
    if (ill) return {1'b1, 32'h13};
    f7 = (op == 5 || op == 9) ? 32 : 0;
    w  = rd * 128 + f3tab[op] * 4096 + rs1 * 32768;
    if (rf)
      w = w + 'h33 + rs2 * 1048576 + f7 * 33554432;
    else if (sh)
      w = w + 'h13 + (imm % 32) * 1048576 + f7 * 33554432;
    else
      w = w + 'h13 + longint'(imm) * 1048576;
    return {1'b0, w[31:0]};
  endfunction

  task automatic lit(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      lit("in_ready", {31'd0, in_ready},
          {31'd0, e_run && e_rem != 0});
      lit("busy", {31'd0, busy}, {31'd0, e_run});
      lit("imem_we", {31'd0, imem_we}, {31'd0, e_we});
      lit("done", {31'd0, done}, {31'd0, e_done});
      lit("err_cnt", {24'd0, err_cnt}, e_err);
      if (e_we) begin
        lit("imem_addr", {24'd0, imem_addr}, {24'd0, e_addr});
        lit("imem_wdata", imem_wdata, e_wd);
      end
    end
  end

  task automatic tick();
    bit          r;
    int          rem;
    int          ptr;
    int          err;
    bit          we;
    bit          dn;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [32:0] enc;
    r = e_run; rem = e_rem; ptr = e_ptr; err = e_err;
    we = 0; dn = 0; a = e_addr; wd = e_wd;
    if (r) begin
      if (rem == 0) begin
        r = 0; dn = 1;
      end else if (in_valid) begin
        enc = ref_enc(in_alu_op, in_is_from_rf, in_rd,
                      in_rs1, in_rs2, in_imm12);
        we = 1; a = ptr[7:0]; wd = enc[31:0];
        ptr = (ptr + 1) % 256;
        if (enc[32] && err < 255) err++;
        rem--;
        if (rem == 0) begin
          r = 0; dn = 1;
        end
      end
    end else if (start) begin
      r = 1; ptr = base_addr; rem = len; err = 0;
    end
    @(posedge clk);
    e_run = r; e_rem = rem; e_ptr = ptr; e_err = err;
    e_we = we; e_done = dn; e_addr = a; e_wd = wd;
    #1;
  endtask

  task automatic model_reset();
    e_run = 0; e_rem = 0; e_ptr = 0; e_err = 0;
    e_we = 0; e_done = 0; e_addr = '0; e_wd = '0;
  endtask

  task automatic set_req(input int op, input bit rf,
                         input int rd, input int rs1,
                         input int rs2, input int imm);
    in_valid = 1'b1;
    in_alu_op = op[4:0];
    in_is_from_rf = rf;
    in_rd = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_imm12 = imm[11:0];
  endtask

  task automatic start_run(input int b, input int l);
    base_addr = b[7:0];
    len = l[7:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [32:0] pin;
  int          cyc;
  int          ln;

  initial begin
    model_reset();
    #12;
    lit("rst_we", {31'd0, imem_we}, 32'd0);
    lit("rst_addr", {24'd0, imem_addr}, 32'd0);
    lit("rst_wdata", imem_wdata, 32'd0);
    lit("rst_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    pin = ref_enc(1, 0, 1, 0, 0, 5);
    lit("model_addi", pin[31:0], 32'h00500093);
    pin = ref_enc(9, 0, 5, 6, 0, 3);
    lit("model_srai", pin[31:0], 32'h40335293);
    pin = ref_enc(8, 0, 1, 1, 0, 'h23);
    lit("model_bad_srli", pin, {1'b1, 32'h13});

    start_run('h10, 1);
    set_req(1, 0, 1, 0, 0, 5);
    tick();
    in_valid = 1'b0;
    lit("addi_we", {31'd0, imem_we}, 32'd1);
    lit("addi_addr", {24'd0, imem_addr}, 32'h10);
    lit("addi_word", imem_wdata, 32'h00500093);
    lit("addi_done", {31'd0, done}, 32'd1);
    tick();

    start_run(0, 2);
    set_req(1, 1, 3, 1, 2, 0);
    tick();
    lit("add_word", imem_wdata, 32'h002081B3);
    lit("add_done", {31'd0, done}, 32'd0);
    set_req(5, 1, 3, 1, 2, 0);
    tick();
    in_valid = 1'b0;
    lit("sub_word", imem_wdata, 32'h402081B3);
    lit("sub_addr", {24'd0, imem_addr}, 32'h01);
    lit("sub_done", {31'd0, done}, 32'd1);
    tick();

    start_run(0, 2);
    set_req(9, 0, 5, 6, 0, 3);
    tick();
    lit("srai_word", imem_wdata, 32'h40335293);
    set_req(8, 0, 5, 6, 0, 'h23);
    tick();
    in_valid = 1'b0;
    lit("srli_nop", imem_wdata, 32'h00000013);
    lit("srli_err", {24'd0, err_cnt}, 32'd1);
    tick();

    start_run('hFF, 2);
    set_req(1, 0, 2, 2, 0, 1);
    tick();
    lit("wrap_a0", {24'd0, imem_addr}, 32'hFF);
    in_valid = 1'b0;
    tick();
    lit("gap_we", {31'd0, imem_we}, 32'd0);
    set_req(1, 0, 2, 2, 0, 1);
    tick();
    in_valid = 1'b0;
    lit("wrap_a1", {24'd0, imem_addr}, 32'h00);
    tick();

    start_run('h50, 0);
    set_req(1, 0, 1, 1, 0, 1);
    tick();
    in_valid = 1'b0;
    lit("len0_done", {31'd0, done}, 32'd1);
    lit("len0_we", {31'd0, imem_we}, 32'd0);
    tick();

    start_run('h40, 2);
    set_req(1, 0, 1, 1, 0, 1);
    tick();
    start = 1'b1; base_addr = 8'h80; len = 8'd5;
    tick();
    start = 1'b0; in_valid = 1'b0;
    lit("restart_ign", {24'd0, imem_addr}, 32'h41);
    tick();

    start_run('h20, 3);
    set_req(1, 0, 1, 1, 0, 1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    lit("abort_we", {31'd0, imem_we}, 32'd0);
    lit("abort_busy", {31'd0, busy}, 32'd0);
    lit("abort_addr", {24'd0, imem_addr}, 32'd0);
    lit("abort_wdata", imem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_run('h30, 1);
    set_req(1, 0, 1, 1, 0, 1);
    tick();
    in_valid = 1'b0;
    lit("fresh_addr", {24'd0, imem_addr}, 32'h30);
    tick();

    start_run(7, 255);
    set_req(0, 1, 1, 1, 1, 0);
    repeat (255) tick();
    in_valid = 1'b0;
    lit("err_full", {24'd0, err_cnt}, 32'd255);
    tick();

    for (int run = 0; run < 40; run++) begin
      ln = (run % 10 == 9) ? 0 : int'($urandom_range(1, 14));
      start_run($urandom % 256, ln);
      cyc = 0;
      while (e_run && cyc < 2000) begin
        set_req($urandom % 13, $urandom % 2,
                $urandom % 32, $urandom % 32,
                $urandom % 32,
                ($urandom % 2) ? $urandom % 40
                               : $urandom % 4096);
        in_valid = ($urandom % 4) != 0;
        start = ($urandom % 8) == 0;
        base_addr = $urandom % 256;
        len = $urandom % 256;
        tick();
        cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      if (e_run) begin
        n_cmp++;
        n_bad++;
        $display("FAIL run_timeout: run %0d still busy", run);
      end
      tick();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
